// File: rtl/fft_pkg.sv
// Shared types and defaults for the sequential 16-point FFT controller.
package fft_pkg;

  localparam int unsigned BEATS_DEF  = 4;
  localparam int unsigned STAGES_DEF = 4;
  localparam int unsigned BF_LAT_DEF = 2;
  localparam int unsigned ROT_W      = 3;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned STAGE_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    FINAL,
    DRAIN
  } state_t;

  // Tag travelling alongside a beat through the butterfly latency.
  typedef struct packed {
    logic vld;
    logic fin;
  } tag_t;

  // Twiddle index: twice the beat index scaled by the stage, modulo 8.
  function automatic logic [ROT_W-1:0] rot_calc(input logic [ADDR_W-1:0]  cnt,
                                                input logic [STAGE_W-1:0] stg);
    logic [ROT_W-1:0] base;
    base = ROT_W'({cnt, 1'b0});
    return base << stg;
  endfunction

endpackage

// File: rtl/fft_seq_tagpipe.sv
// Delay line matching the butterfly latency; carries valid and final-stage flag.
module fft_seq_tagpipe
  import fft_pkg::*;
#(
  parameter int unsigned BF_LAT = BF_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe_q [BF_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BF_LAT); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < int'(BF_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[BF_LAT-1];

endmodule

// File: rtl/fft_seq.sv
// Sequencer for an in-place radix-2 FFT over a reg1 beat buffer.
// Optional sticky protocol error output enabled by FFT_SEQ_ERR_EN.
module fft_seq
  import fft_pkg::*;
#(
  parameter int unsigned BEATS  = BEATS_DEF,
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned BF_LAT = BF_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sp_valid,
  output logic               sp_ready,
  input  logic               ps_ready,
  output logic               mux_sel,
  output logic               bf_valid,
  output logic [ROT_W-1:0]   rotation,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               demux_sel,
  output logic               ps_load,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               done
`ifdef FFT_SEQ_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int unsigned     LAT_W     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(BF_LAT - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  issue_cnt_q;
  logic [ADDR_W-1:0]  ret_cnt_q;
  logic [LAT_W-1:0]   drain_cnt_q;
  logic [STAGE_W-1:0] stage_q;
  logic               ret_flag_q;
  logic               done_q;

  logic issue_adv_c;
  logic last_ret_c;
  logic ret_all_c;
  logic next_final_c;
  logic done_c;
  tag_t tag_in;
  tag_t tag_out;

  // Stage fully retired: either remembered, or the last write exits now.
  assign last_ret_c   = tag_out.vld && !tag_out.fin && (ret_cnt_q == LAST_BEAT);
  assign ret_all_c    = ret_flag_q || last_ret_c;
  assign next_final_c = (32'(stage_q) + 32'd1) >= 32'(STAGES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sp_ready    = 1'b0;
    mux_sel     = 1'b0;
    bf_valid    = 1'b0;
    rd_addr     = '0;
    busy        = 1'b1;
    issue_adv_c = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (sp_valid) state_d = LOAD;
      end
      LOAD: begin
        sp_ready    = 1'b1;
        bf_valid    = sp_valid;
        issue_adv_c = sp_valid;
        if (sp_valid && (issue_cnt_q == LAST_BEAT)) state_d = WAIT;
      end
      WAIT: begin
        if (ret_all_c) begin
          if (!next_final_c)  state_d = ISSUE;
          else if (ps_ready)  state_d = FINAL;
        end
      end
      ISSUE, FINAL: begin
        mux_sel     = 1'b1;
        bf_valid    = 1'b1;
        rd_addr     = issue_cnt_q;
        issue_adv_c = 1'b1;
        if (issue_cnt_q == LAST_BEAT) state_d = (state_q == ISSUE) ? WAIT : DRAIN;
      end
      DRAIN: begin
        if (drain_cnt_q == LAST_LAT) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and stage tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      drain_cnt_q <= '0;
      stage_q     <= '0;
      ret_flag_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (state_q == IDLE)
        issue_cnt_q <= '0;
      else if (issue_adv_c)
        issue_cnt_q <= (issue_cnt_q == LAST_BEAT) ? '0 : issue_cnt_q + ADDR_W'(1);

      if (state_q == IDLE)
        ret_cnt_q <= '0;
      else if (tag_out.vld)
        ret_cnt_q <= (ret_cnt_q == LAST_BEAT) ? '0 : ret_cnt_q + ADDR_W'(1);

      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + LAT_W'(1) : '0;
      ret_flag_q  <= (state_q == WAIT) && (state_d == WAIT) && ret_all_c;

      if (state_d == IDLE)
        stage_q <= '0;
      else if ((state_q == WAIT) && (state_d != WAIT))
        stage_q <= stage_q + STAGE_W'(1);

      done_q <= done_c;
    end
  end

  assign rotation = bf_valid ? rot_calc(issue_cnt_q, stage_q) : '0;
  assign tag_in   = '{vld: bf_valid, fin: (state_q == FINAL)};

  fft_seq_tagpipe #(
    .BF_LAT (BF_LAT)
  ) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign wr_en     = tag_out.vld && !tag_out.fin;
  assign ps_load   = tag_out.vld && tag_out.fin;
  assign demux_sel = ps_load;
  assign wr_addr   = ret_cnt_q;
  assign stage     = stage_q;
  assign done      = done_q;

`ifdef FFT_SEQ_ERR_EN
  // Sticky: new input offered while a frame is being processed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (sp_valid && (state_q inside {ISSUE, WAIT, FINAL, DRAIN}))
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fft_seq.sv
// Scoreboard bench for fft_seq: issued beats queue their expected retirements.
module tb_fft_seq;
  import fft_pkg::*;

  localparam int BEATS  = 4;
  localparam int STAGES = 4;
  localparam int BF_LAT = 2;

  logic               clk;
  logic               rst;
  logic               sp_valid;
  logic               sp_ready;
  logic               ps_ready;
  logic               mux_sel;
  logic               bf_valid;
  logic [ROT_W-1:0]   rotation;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               demux_sel;
  logic               ps_load;
  logic [STAGE_W-1:0] stage;
  logic               busy;
  logic               done;
`ifdef FFT_SEQ_ERR_EN
  logic               err;
`endif

  fft_seq dut (
    .clk       (clk),
    .rst       (rst),
    .sp_valid  (sp_valid),
    .sp_ready  (sp_ready),
    .ps_ready  (ps_ready),
    .mux_sel   (mux_sel),
    .bf_valid  (bf_valid),
    .rotation  (rotation),
    .rd_addr   (rd_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .demux_sel (demux_sel),
    .ps_load   (ps_load),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
`ifdef FFT_SEQ_ERR_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int addr;
    bit fin;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   bf_k = 0;
  int   exp_stage = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  function automatic int rot_ref(input int k, input int s);
    return ((2 * k) << s) % 8;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_sp_ready"},  sp_ready,  0);
    chk({tag, "_mux_sel"},   mux_sel,   0);
    chk({tag, "_bf_valid"},  bf_valid,  0);
    chk({tag, "_rotation"},  rotation,  0);
    chk({tag, "_rd_addr"},   rd_addr,   0);
    chk({tag, "_wr_en"},     wr_en,     0);
    chk({tag, "_wr_addr"},   wr_addr,   0);
    chk({tag, "_demux_sel"}, demux_sel, 0);
    chk({tag, "_ps_load"},   ps_load,   0);
    chk({tag, "_stage"},     stage,     0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  // Monitor: every butterfly issue predicts a retirement BF_LAT cycles later.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      bf_k      = 0;
      exp_stage = 0;
    end else begin
      if (bf_valid) begin
        chk("mux_sel", mux_sel, exp_stage != 0);
        chk("stage", stage, exp_stage);
        chk("rotation", rotation, rot_ref(bf_k, exp_stage));
        if (exp_stage != 0) chk("rd_addr", rd_addr, bf_k);
        exp_q.push_back('{cyc + BF_LAT, bf_k, exp_stage == STAGES - 1});
        bf_k++;
        if (bf_k == BEATS) begin
          bf_k = 0;
          exp_stage++;
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        chk("wr_en", wr_en, !mon_e.fin);
        chk("ps_load", ps_load, mon_e.fin);
        chk("demux_sel", demux_sel, mon_e.fin);
        if (!mon_e.fin) chk("wr_addr", wr_addr, mon_e.addr);
      end else begin
        chk("spurious_wr", {wr_en, ps_load}, 0);
      end
      if (done) begin
        chk("done_drained", exp_q.size(), 0);
        exp_stage = 0;
        bf_k      = 0;
      end
    end
  end

  // One frame: kick from IDLE, then drive pat (bit 0 first) from the first LOAD cycle.
  task automatic run_frame(input logic [15:0] pat, input int plen, input int rel,
                           input int abort_at, output int n_done, output int acc);
    int n;
    n      = 0;
    acc    = 0;
    n_done = -1;
    if (rel > 0) ps_ready = 1'b0;
    @(posedge clk); #1 sp_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", sp_ready, 0);
    while (n_done < 0 && n < 60) begin
      @(posedge clk); #1;
      sp_valid = (n < plen) ? pat[n] : 1'b0;
      if (rel > 0 && n + 1 == rel) ps_ready = 1'b1;
      if (abort_at > 0 && n + 1 == abort_at) begin
        rst = 1'b1;
        #1 check_zero("abort");
      end
      if (abort_at > 0 && n + 1 == abort_at + 2) rst = 1'b0;
      @(negedge clk);
      n++;
      if (sp_valid && sp_ready) acc++;
      if (rel > 0 && n >= 17 && n <= rel) chk("bp_hold", bf_valid, 0);
      if (rel > 0 && n == rel + 1) chk("bp_final", {bf_valid, stage}, {1'b1, 2'd3});
      if (done) n_done = n;
    end
    sp_valid = 1'b0;
    ps_ready = 1'b1;
  endtask

  int nd;
  int acc;

  initial begin
    rst      = 1'b1;
    sp_valid = 1'b0;
    ps_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    run_frame(16'h000F, 4, 0, 0, nd, acc);
    chk("nominal_cycles", nd, 25);
    chk("nominal_accepts", acc, 4);

    run_frame(16'h002D, 6, 0, 0, nd, acc);
    chk("gapped_cycles", nd, 27);
    chk("gapped_accepts", acc, 4);

    run_frame(16'h000F, 4, 22, 0, nd, acc);
    chk("backpressure_cycles", nd, 29);

    run_frame(16'h000F, 4, 0, 8, nd, acc);
    chk("abort_no_done", nd, -1);

    run_frame(16'h000F, 4, 0, 0, nd, acc);
    chk("recovery_cycles", nd, 25);

`ifdef FFT_SEQ_ERR_EN
    chk("err_clear", err, 0);
    run_frame(16'h001F, 5, 0, 0, nd, acc);
    chk("err_frame_cycles", nd, 25);
    chk("err_sticky", err, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("err_rst", err, 0);
    @(posedge clk); #1 rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
